// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with a show-ahead receive FIFO.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) on rx, rejects false starts, and
// stores each completed word with its framing and parity error flags in a
// FIFO_DEPTH-entry FIFO drained through a valid/ready handshake.
//
// Ports:
//   clk_50M        system clock, rising edge
//   rst            synchronous active-high reset
//   rx             asynchronous serial input, idle high
//   rx_msg         head-of-FIFO data word (0 when empty)
//   rx_frame_err   head word had a low stop bit
//   rx_parity_err  head word failed parity
//   rx_valid       FIFO non-empty
//   rx_ready       consumer accepts head word when high with rx_valid
//   overrun        one-cycle pulse: completed word dropped, FIFO full
//   fifo_count     number of stored words
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50M,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_msg,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]    BIT_ONE   = 4'd1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  // Odd parity expects data ^ parity bit == 1, even expects 0.
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d,
                                       input logic s);
    logic expected;
    expected = (PARITY == 1);
    return (((^d) ^ s) != expected);
  endfunction

  // Synchronizer plus previous-value register for falling-edge detection.
  logic meta_q, rxs_q, prev_q;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
      prev_q <= rxs_q;
    end
  end

  // Receive FSM.
  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  ferr_q, ferr_d, perr_q, perr_d;
  logic                  push_q, push_d;
  logic [WW-1:0]         pword_q, pword_d;
  logic                  mid;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    pword_d = pword_q;
    mid     = (baud_q == BIT_LAST);
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (prev_q && !rxs_q) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (mid) begin
          baud_d  = '0;
          perr_d  = parity_fail(shift_q, rxs_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          baud_d = '0;
          ferr_d = ferr_q | ~rxs_q;
          if (bit_q == STOP_LAST) begin
            push_d  = 1'b1;
            pword_d = {ferr_q | ~rxs_q, perr_q, shift_q};
            // A low final stop bit (break) must not retrigger a frame.
            state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_WAIT_HIGH: begin
        baud_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
    end
  end

  always_ff @(posedge clk_50M) begin
    shift_q <= shift_d;
    pword_q <= pword_d;
  end

  // Receive FIFO: entry = {frame_err, parity_err, data}.
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovr_q;
  logic          full, valid, pop, wr_en;
  logic [WW-1:0] head;

  assign full  = (cnt_q == CNT_FULL);
  assign valid = (cnt_q != '0);
  assign pop   = valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + PTR_ONE;
      if (pop)   rd_q <= rd_q + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      ovr_q <= push_q & full & ~pop;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (wr_en) mem_q[wr_q] <= pword_q;
  end

  // Outputs are gated by valid so they read 0 whenever the FIFO is empty.
  assign head          = mem_q[rd_q];
  assign rx_msg        = valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = valid & head[DATA_BITS];
  assign rx_frame_err  = valid & head[DATA_BITS+1];
  assign rx_valid      = valid;
  assign overrun       = ovr_q;
  assign fifo_count    = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with even parity,
// 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_msg;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt  = 0;
  logic [9:0] got_q[$];

  uart_rx_fifo #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .rx(rx),
    .rx_msg(rx_msg), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk_50M = ~clk_50M;

  // Record every accepted word {frame_err, parity_err, data} and overrun pulses.
  always @(negedge clk_50M) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_frame_err, rx_parity_err, rx_msg});
    if (overrun) ovr_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] next_word();
    if (got_q.size() > 0) return got_q.pop_front();
    return 10'h3FF;
  endfunction

  // Frame: start, 8 data LSB first, even parity (optionally flipped), stop.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = (^d) ^ par_flip;
    tick(CPB);
    rx = stop_v;
    tick(CPB);
  endtask

  logic [7:0] exp_b [20];
  int base;

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_msg", rx_msg, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_perr", rx_parity_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_count", fifo_count, 0);
    rst = 1'b0;
    tick(5);

    // Back-to-back random bytes, consumer always ready.
    for (int i = 0; i < 20; i++) begin
      exp_b[i] = 8'($urandom);
      send_frame(exp_b[i], 1'b0, 1'b1);
    end
    tick(20);
    check("b2b_n", got_q.size(), 20);
    for (int i = 0; i < 20; i++) check("b2b_word", next_word(), {2'b00, exp_b[i]});
    check("b2b_ovr", ovr_cnt, 0);
    got_q.delete();

    // Parity: correct then flipped.
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(20);
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(20);
    check("par_n", got_q.size(), 2);
    check("par_ok", next_word(), 10'h0A5);
    check("par_bad", next_word(), 10'h1A5);
    got_q.delete();

    // Low stop bit followed by a held-low line, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(3 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'h55, 1'b0, 1'b1);
    tick(20);
    check("brk_n", got_q.size(), 2);
    check("brk_word", next_word(), 10'h23C);
    check("brk_next", next_word(), 10'h055);
    got_q.delete();

    // Short glitch must not start a frame; a following frame still works.
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_n", got_q.size(), 0);
    send_frame(8'h0F, 1'b0, 1'b1);
    tick(20);
    check("glitch_after", next_word(), 10'h00F);
    got_q.delete();

    // Overrun: consumer stalled, five words into four entries.
    base = ovr_cnt;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    tick(20);
    check("ovr_count", fifo_count, 4);
    check("ovr_pulses", ovr_cnt - base, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_msg, 8'h01);
    rx_ready = 1'b1;
    tick(8);
    check("drain_n", got_q.size(), 4);
    for (int i = 1; i <= 4; i++) check("drain_word", next_word(), 10'(i));
    check("drain_count", fifo_count, 0);
    got_q.delete();

    // Reset in the middle of a frame with a word already queued.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    tick(20);
    check("pre_rst_count", fifo_count, 1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h7E >> i) & 1'b1;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_valid", rx_valid, 0);
    check("mrst_msg", rx_msg, 0);
    check("mrst_ferr", rx_frame_err, 0);
    check("mrst_perr", rx_parity_err, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_count", fifo_count, 0);
    tick(3 * CPB);
    rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'h81, 1'b0, 1'b1);
    tick(20);
    check("post_rst_n", got_q.size(), 1);
    check("post_rst_word", next_word(), 10'h081);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
